// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: main FSM, ALU decode, NZCV flag register and
// condition check driving the datapath enables and mux selects.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemB,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        unused_instr;

  logic        cond_ex;
  logic [2:0]  alu_op;
  logic        alu_mov;
  logic        alu_arith;
  logic        no_write;
  logic        in_exec;

  assign cond  = Instr[19:16];
  assign op    = Instr[13:12];
  assign funct = Instr[11:6];
  assign rd    = Instr[3:0];
  assign unused_instr = ^{Instr[15:14], Instr[5:4]};

  assign State    = state_q;
  assign in_exec  = (state_q == StExecR) || (state_q == StExecI);
  // CMP and TST only set flags, they never write a register.
  assign no_write = (funct[4:1] == 4'b1010) || (funct[4:1] == 4'b1000);

  // Condition is checked against the stored flags so an S-instruction's own
  // update cannot change whether it executes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op    = AluAdd;
    alu_mov   = 1'b0;
    alu_arith = 1'b1;
    case (funct[4:1])
      4'b0010, 4'b1010: alu_op = AluSub;
      4'b0000, 4'b1000: begin
        alu_op    = AluAnd;
        alu_arith = 1'b0;
      end
      4'b1100: begin
        alu_op    = AluOrr;
        alu_arith = 1'b0;
      end
      4'b0001: begin
        alu_op    = AluEor;
        alu_arith = 1'b0;
      end
      4'b1101: begin
        alu_mov   = 1'b1;
        alu_arith = 1'b0;
      end
      default: alu_op = AluAdd;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (in_exec && cond_ex && funct[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (alu_arith) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemB       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = AluAdd;
    case (state_q)
      StFetch: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        state_d   = MemReady ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        AdrSrc  = 1'b1;
        MemB    = funct[2];
        state_d = MemReady ? StMemWb : StMemRd;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        state_d   = StFetch;
      end
      StMemWr: begin
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
        MemB     = funct[2];
        MemWrite = cond_ex;
        state_d  = MemReady ? StFetch : StMemWr;
      end
      StExecR, StExecI: begin
        ALUSrcA    = alu_mov ? 2'b10 : 2'b00;
        ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
        ALUControl = alu_op;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite = cond_ex & ~no_write;
        PCWrite  = cond_ex & ~no_write & (rd == 4'hF);
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        RegSrc    = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Architectural writes are suppressed for the whole reset cycle.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: reference model compared every cycle plus directed
// instruction sequences with literal expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, MemB, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemB       (MemB),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .State      (State)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_state;
  logic [3:0] m_flags;
  bit         m_valid = 1'b0;

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [2:0] m_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 3'd1;
      4'b0000, 4'b1000: return 3'd2;
      4'b1100:          return 3'd3;
      4'b0001:          return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic int m_next(input int st, input logic [19:0] ins, input logic rdy);
    logic [1:0] op;
    op = ins[13:12];
    case (st)
      0: return rdy ? 1 : 0;
      1: return (op == 2'd1) ? 2 : (op == 2'd2) ? 9 : (op == 2'd3) ? 0 : (ins[11] ? 7 : 6);
      2: return ins[6] ? 3 : 5;
      3: return rdy ? 4 : 3;
      5: return rdy ? 0 : 5;
      6, 7: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags_next(input int st, input logic [19:0] ins,
                                              input logic [3:0] f, input logic [3:0] af);
    logic [3:0] cmd, nf;
    cmd = ins[10:7];
    nf  = f;
    if ((st == 6 || st == 7) && m_cond(ins[19:16], f) && ins[6]) begin
      nf[3:2] = af[3:2];
      if (m_alu(cmd) <= 3'd1 && cmd != 4'b1101) nf[1:0] = af[1:0];
    end
    return nf;
  endfunction

  function automatic logic [22:0] m_out(input int st, input logic [19:0] ins, input logic [3:0] f,
                                        input logic rdy, input logic rst);
    logic pcw, irw, rw, mw, mb, adr, ce;
    logic [1:0] res, sa, sb, imm, rs;
    logic [2:0] alu;
    logic [5:0] fn;
    {pcw, irw, rw, mw, mb, adr} = 6'b0;
    {res, sa, sb, imm, rs} = 10'b0;
    alu = 3'd0;
    fn  = ins[11:6];
    ce  = m_cond(ins[19:16], f);
    case (st)
      0: begin sa = 1; sb = 2; res = 2; pcw = rdy; irw = rdy; end
      1: begin sa = 1; sb = 2; res = 2; end
      2: begin sb = 1; imm = 1; end
      3: begin adr = 1; mb = fn[2]; end
      4: begin res = 1; rw = ce; end
      5: begin adr = 1; rs = 2; mb = fn[2]; mw = ce; end
      6, 7: begin
        sb  = (st == 7) ? 2'd1 : 2'd0;
        alu = m_alu(fn[4:1]);
        sa  = (fn[4:1] == 4'b1101) ? 2'd2 : 2'd0;
      end
      8: begin
        rw  = ce && fn[4:1] != 4'b1010 && fn[4:1] != 4'b1000;
        pcw = rw && ins[3:0] == 4'hF;
      end
      9: begin sa = 1; sb = 1; imm = 2; rs = 1; res = 2; pcw = ce; end
      default: ;
    endcase
    if (rst) {pcw, irw, rw, mw} = 4'b0;
    return {4'(st), pcw, irw, rw, mw, mb, adr, res, sa, sb, imm, rs, alu};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0;
      m_flags <= 4'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_state <= m_next(m_state, Instr, MemReady);
      m_flags <= m_flags_next(m_state, Instr, m_flags, ALUFlags);
    end
  end

  logic [22:0] dut_vec;
  assign dut_vec = {State, PCWrite, IRWrite, RegWrite, MemWrite, MemB, AdrSrc, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  always @(negedge clk) begin
    if (m_valid) check("cycle_outputs", 32'(dut_vec),
                       32'(m_out(m_state, Instr, m_flags, MemReady, reset)));
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] fn, input logic [3:0] rd);
    return {c, 2'b00, op, fn, 2'b00, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_decode_next(input logic [19:0] ins);
    Instr    = ins;
    MemReady = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = 4'b0;
    MemReady = 1'b1;
    tick();
    tick();
    check("rst_state", State, 0);
    check("rst_pcwrite_forced", PCWrite, 0);
    check("rst_irwrite_forced", IRWrite, 0);
    reset = 1'b0;
    #1;
    check("fetch_irwrite", IRWrite, 1);

    // ADD R1, #imm
    Instr = mk(4'b1110, 2'b00, 6'b101000, 4'd1);
    tick();
    check("add_decode", State, 1);
    tick();
    check("add_execi", State, 7);
    check("add_execi_alu", ALUControl, 3'b000);
    check("add_execi_rw", RegWrite, 0);
    tick();
    check("add_aluwb", State, 8);
    check("add_aluwb_rw", RegWrite, 1);
    tick();
    check("add_back_fetch", State, 0);

    // LDR with three wait cycles in MEMRD
    to_decode_next(mk(4'b1110, 2'b01, 6'b011001, 4'd2));
    check("ldr_memadr", State, 2);
    MemReady = 1'b0;
    tick();
    check("ldr_memrd1", State, 3);
    check("ldr_memrd_rw", RegWrite, 0);
    tick();
    tick();
    check("ldr_memrd3", State, 3);
    MemReady = 1'b1;
    tick();
    check("ldr_memwb", State, 4);
    check("ldr_memwb_rw", RegWrite, 1);
    tick();
    check("ldr_fetch_rw", RegWrite, 0);

    // SUBS R0 with Z result, then BEQ / BNE
    ALUFlags = 4'b0100;
    to_decode_next(mk(4'b1110, 2'b00, 6'b000101, 4'd0));
    check("subs_execr", State, 6);
    check("subs_alu", ALUControl, 3'b001);
    tick();
    ALUFlags = 4'b0000;
    tick();
    to_decode_next(mk(4'b0000, 2'b10, 6'b000000, 4'd0));
    check("beq_state", State, 9);
    check("beq_pcwrite", PCWrite, 1);
    tick();
    to_decode_next(mk(4'b0001, 2'b10, 6'b000000, 4'd0));
    check("bne_pcwrite", PCWrite, 0);
    tick();

    // CMP sets N, no register write
    ALUFlags = 4'b1000;
    to_decode_next(mk(4'b1110, 2'b00, 6'b010101, 4'd3));
    tick();
    check("cmp_aluwb", State, 8);
    check("cmp_rw", RegWrite, 0);
    ALUFlags = 4'b0000;
    tick();
    to_decode_next(mk(4'b0100, 2'b10, 6'b000000, 4'd0));
    check("bmi_pcwrite", PCWrite, 1);
    tick();

    // STREQ with Z=0: never writes
    to_decode_next(mk(4'b0000, 2'b01, 6'b011000, 4'd3));
    MemReady = 1'b0;
    tick();
    check("streq_memwr", State, 5);
    check("streq_mw0", MemWrite, 0);
    tick();
    check("streq_mw1", MemWrite, 0);
    MemReady = 1'b1;
    #1;
    check("streq_mw2", MemWrite, 0);
    tick();

    // STR always: MemWrite held through waits, then reset mid-wait
    to_decode_next(mk(4'b1110, 2'b01, 6'b011100, 4'd3));
    MemReady = 1'b0;
    tick();
    check("str_mw_wait1", MemWrite, 1);
    check("str_memb", MemB, 1);
    tick();
    check("str_mw_wait2", MemWrite, 1);
    reset = 1'b1;
    #1;
    check("str_mw_in_reset", MemWrite, 0);
    tick();
    reset = 1'b0;
    #1;
    check("str_reset_state", State, 0);
    check("str_reset_mw", MemWrite, 0);
    to_decode_next(mk(4'b0101, 2'b10, 6'b000000, 4'd0));
    check("bpl_after_reset", PCWrite, 1);
    tick();

    // MOV PC, R2
    to_decode_next(mk(4'b1110, 2'b00, 6'b011010, 4'hF));
    check("mov_srca", ALUSrcA, 2'b10);
    tick();
    check("mov_pcwrite", PCWrite, 1);
    check("mov_regwrite", RegWrite, 1);
    tick();

    // Op=11 returns to FETCH from DECODE
    to_decode_next(mk(4'b1110, 2'b11, 6'b000000, 4'd0));
    check("op11_fetch", State, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
